// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM state
// encodings and the default operand width.
package seq_multiplier_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add datapath: operand magnitude capture, accumulator, shift
// registers and the final conditional negation into the product register.
module mul_datapath
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic               neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  // The most negative operand's magnitude still fits in WIDTH unsigned bits.
  always_comb begin
    a_mag    = (signed_mode && a[WIDTH-1]) ? (~a + 1'b1) : a;
    b_mag    = (signed_mode && b[WIDTH-1]) ? (~b + 1'b1) : b;
    acc_next = mplier[0] ? (acc + mcand) : acc;
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (load) begin
      mcand   <= {{WIDTH{1'b0}}, a_mag};
      acc     <= '0;
      mplier  <= b_mag;
      neg     <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (finish) begin
        product <= neg ? (~acc_next + 1'b1) : acc_next;
      end
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier: control FSM, step counter and
// start/busy/done handshake around the shift-add datapath.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             load;
  logic             step;
  logic             finish;

  always_ff @(posedge clk) begin
    if (!areset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // DONE accepts a new start directly, giving back-to-back operation.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        busy     = 1'b1;
        step     = 1'b1;
        cnt_next = cnt + 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          finish     = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  mul_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .areset     (areset),
    .load       (load),
    .step       (step),
    .finish     (finish),
    .signed_mode(signed_mode),
    .a          (A),
    .b          (B),
    .product    (product)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=8 and WIDTH=16, using
// expected-product queues filled at stimulus time and drained on done.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        areset;
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] prod16;

  logic [15:0] q8[$];
  logic [31:0] q16[$];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .areset(areset), .start(start8), .signed_mode(sm8),
    .A(a8), .B(b8), .busy(busy8), .done(done8), .product(prod8)
  );

  seq_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .areset(areset), .start(start16), .signed_mode(sm16),
    .A(a16), .B(b16), .busy(busy16), .done(done16), .product(prod16)
  );

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    longint p;
    if (sm) p = longint'($signed(a)) * longint'($signed(b));
    else    p = longint'(a) * longint'(b);
    return p[15:0];
  endfunction

  function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b, input logic sm);
    longint p;
    if (sm) p = longint'($signed(a)) * longint'($signed(b));
    else    p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm, input string nm);
    int lat;
    logic busy_ok;
    logic [15:0] exp;
    a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
    q8.push_back(model8(a, b, sm));
    tick();
    start8 = 1'b0; a8 = ~a; b8 = ~b;
    lat = 0; busy_ok = 1'b1;
    while (!done8 && lat < 20) begin
      if (busy8 !== 1'b1) busy_ok = 1'b0;
      tick();
      lat++;
    end
    total++;
    if (lat !== 8) $display("FAIL %s latency: got %0d expected 8", nm, lat);
    else passed++;
    total++;
    if (!busy_ok) $display("FAIL %s busy_run: busy got 0 expected 1 during RUN", nm);
    else passed++;
    exp = q8.pop_front();
    total++;
    if (done8 !== 1'b1 || prod8 !== exp)
      $display("FAIL %s product: got %h (done=%b) expected %h", nm, prod8, done8, exp);
    else passed++;
    total++;
    if (busy8 !== 1'b0) $display("FAIL %s busy_at_done: got %b expected 0", nm, busy8);
    else passed++;
    tick();
    total++;
    if (done8 !== 1'b0 || prod8 !== exp)
      $display("FAIL %s hold: done=%b product=%h expected done=0 product=%h", nm, done8, prod8, exp);
    else passed++;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sm, input string nm);
    int lat;
    logic [31:0] exp;
    a16 = a; b16 = b; sm16 = sm; start16 = 1'b1;
    q16.push_back(model16(a, b, sm));
    tick();
    start16 = 1'b0; a16 = ~a; b16 = ~b;
    lat = 0;
    while (!done16 && lat < 40) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== 16) $display("FAIL %s latency: got %0d expected 16", nm, lat);
    else passed++;
    exp = q16.pop_front();
    total++;
    if (done16 !== 1'b1 || prod16 !== exp)
      $display("FAIL %s product: got %h (done=%b) expected %h", nm, prod16, done16, exp);
    else passed++;
    tick();
  endtask

  task automatic test_reset();
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) $display("FAIL reset8_flags: busy=%b done=%b expected 0 0", busy8, done8);
    else passed++;
    total++;
    if (prod8 !== 16'h0) $display("FAIL reset8_product: got %h expected 0000", prod8);
    else passed++;
    total++;
    if (busy16 !== 1'b0 || done16 !== 1'b0 || prod16 !== 32'h0)
      $display("FAIL reset16: busy=%b done=%b product=%h expected 0 0 0", busy16, done16, prod16);
    else passed++;
  endtask

  task automatic test_unsigned();
    run8(8'd123, 8'd23, 1'b0, "u_123x23");
  endtask

  task automatic test_signed();
    run8(8'hFB, 8'd7, 1'b1, "s_m5x7");
    run8(8'h80, 8'h80, 1'b1, "s_m128xm128");
  endtask

  task automatic test_extremes();
    run8(8'hFF, 8'hFF, 1'b0, "u_255x255");
    run8(8'hFF, 8'hFF, 1'b1, "s_m1xm1");
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] exp;
    a8 = 8'd3; b8 = 8'd4; sm8 = 1'b0; start8 = 1'b1;
    q8.push_back(model8(8'd3, 8'd4, 1'b0));
    tick();
    a8 = 8'd10; b8 = 8'd10;
    q8.push_back(model8(8'd10, 8'd10, 1'b0));
    lat = 0;
    while (!done8 && lat < 20) begin tick(); lat++; end
    exp = q8.pop_front();
    total++;
    if (lat !== 8 || prod8 !== exp) $display("FAIL b2b_first: lat=%0d product=%h expected lat=8 product=%h", lat, prod8, exp);
    else passed++;
    tick();
    start8 = 1'b0;
    total++;
    if (done8 !== 1'b0 || busy8 !== 1'b1) $display("FAIL b2b_restart: done=%b busy=%b expected 0 1", done8, busy8);
    else passed++;
    tick(); tick();
    start8 = 1'b1; a8 = 8'd7; b8 = 8'd7;
    tick();
    start8 = 1'b0;
    lat = 3;
    while (!done8 && lat < 20) begin tick(); lat++; end
    exp = q8.pop_front();
    total++;
    if (lat !== 8 || prod8 !== exp) $display("FAIL b2b_second: lat=%0d product=%h expected lat=8 product=%h", lat, prod8, exp);
    else passed++;
    tick(); tick();
    total++;
    if (done8 !== 1'b0 || busy8 !== 1'b0 || prod8 !== exp)
      $display("FAIL b2b_ignored_start: done=%b busy=%b product=%h expected 0 0 %h", done8, busy8, prod8, exp);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    a8 = 8'd123; b8 = 8'd23; sm8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    areset = 1'b0;
    tick();
    total++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0)
      $display("FAIL abort_state: busy=%b done=%b product=%h expected 0 0 0000", busy8, done8, prod8);
    else passed++;
    areset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 === 1'b1) saw_done = 1'b1;
    end
    total++;
    if (saw_done) $display("FAIL abort_no_done: got done pulse expected none");
    else passed++;
    run8(8'd123, 8'd23, 1'b0, "post_abort");
  endtask

  task automatic test_wide();
    run16(16'hFFFF, 16'hFFFF, 1'b0, "w16_ffffxffff");
    run16(16'h0000, 16'h1234, 1'b0, "w16_zero");
  endtask

  initial begin
    areset = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    tick(); tick();
    test_reset();
    areset = 1'b1;
    tick();
    test_unsigned();
    test_signed();
    test_extremes();
    test_back_to_back();
    test_reset_mid();
    test_wide();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
